// File: rtl/x_mux_trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : x_mux_trigger_pkg
// Brief    : Shared width default and sample type for the capture/trigger
//            stage of the delay-line datapath.
// Revision : 1.0 - initial release
// ============================================================================
package x_mux_trigger_pkg;

  // Default tap-sample width of the delay line.
  localparam int WIDTH_DEF = 32;

  // One raw tap-sample word at the default width.
  typedef logic [WIDTH_DEF-1:0] sample_t;

endpackage : x_mux_trigger_pkg
`default_nettype wire

// File: rtl/x_mux_trigger_sample.sv
`default_nettype none
// ============================================================================
// Module   : x_mux_trigger_sample
// Brief    : Two-stage tap-sample pipeline (current / previous) with a
//            full-width change detector between the two stages.
// Revision : 1.0 - initial release
// ============================================================================
module x_mux_trigger_sample
  import x_mux_trigger_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sample,
  output logic             trig
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Capture the raw tap word, then keep one sample of history for the compare.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= data;
      s2 <= s1;
    end
  end

  // Any single-bit difference between consecutive samples is a trigger; both
  // operands are registers, so there is no path from the raw input to trig.
  always_comb begin
    trig = (s1 != s2);
  end

  assign sample = s1;

endmodule : x_mux_trigger_sample
`default_nettype wire

// File: rtl/x_mux_trigger.sv
`default_nettype none
// ============================================================================
// Module   : x_mux_trigger
// Brief    : Capture/trigger stage. Samples the delay-line tap word each
//            clock and loads it into the output snapshot register only when
//            it differs from the previous sample; otherwise holds the last
//            triggered snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module x_mux_trigger
  import x_mux_trigger_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] sample;
  logic             trig;

  x_mux_trigger_sample #(
    .WIDTH (WIDTH)
  ) u_sample (
    .clk    (i_clk),
    .nrst   (i_nrst),
    .data   (i_data),
    .sample (sample),
    .trig   (trig)
  );

  // Snapshot register: reset wins over a pending trigger, a trigger loads the
  // newest sample, and equal consecutive samples leave the snapshot untouched.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      o_data <= '0;
    end else if (trig) begin
      o_data <= sample;
    end
  end

endmodule : x_mux_trigger
`default_nettype wire

// File: tb/tb_x_mux_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_mux_trigger
// Brief    : Directed self-checking bench for x_mux_trigger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_mux_trigger;
  import x_mux_trigger_pkg::*;

  logic        i_clk;
  logic        i_nrst;
  logic [31:0] i_data;
  logic [31:0] o_data;

  int checks = 0;
  int passes = 0;

  x_mux_trigger #(
    .WIDTH (32)
  ) dut (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_data (i_data),
    .o_data (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  initial begin
    // Reset with all-ones input: output must stay zero.
    i_nrst = 1'b0;
    i_data = 32'hFFFF_FFFF;
    tick(); check("rst_edge1", o_data, 32'h0000_0000);
    tick(); check("rst_edge2", o_data, 32'h0000_0000);

    // Single trigger.
    i_nrst = 1'b1;
    i_data = 32'h0000_0000;
    tick(); check("zero_e1", o_data, 32'h0000_0000);
    tick(); check("zero_e2", o_data, 32'h0000_0000);
    tick(); check("zero_e3", o_data, 32'h0000_0000);
    i_data = 32'hAAAA_AAAB;
    tick(); check("trig_e4", o_data, 32'h0000_0000);
    tick(); check("trig_e5", o_data, 32'hAAAA_AAAB);
    tick(); check("trig_e6", o_data, 32'hAAAA_AAAB);
    tick(); check("trig_e7", o_data, 32'hAAAA_AAAB);

    // Hold for 10 edges with no trigger.
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("hold_%0d", k), o_data, 32'hAAAA_AAAB);
      check($sformatf("hold_trig_%0d", k), {31'b0, dut.u_sample.trig}, 32'h0);
    end

    // Single-bit change and change back.
    i_data = 32'hAAAA_AAAA;
    tick(); check("bit_a_e1", o_data, 32'hAAAA_AAAB);
    tick(); check("bit_a_e2", o_data, 32'hAAAA_AAAA);
    i_data = 32'hAAAA_AAAB;
    tick(); check("bit_b_e1", o_data, 32'hAAAA_AAAA);
    tick(); check("bit_b_e2", o_data, 32'hAAAA_AAAB);

    // Back-to-back changes track with 2-edge latency.
    i_data = 32'h1; tick(); check("b2b_0", o_data, 32'hAAAA_AAAB);
    i_data = 32'h2; tick(); check("b2b_1", o_data, 32'h1);
    i_data = 32'h3; tick(); check("b2b_2", o_data, 32'h2);
    i_data = 32'h4; tick(); check("b2b_3", o_data, 32'h3);
    tick(); check("b2b_4", o_data, 32'h4);
    tick(); check("b2b_5", o_data, 32'h4);

    // Reset mid-operation.
    i_data = 32'h1234_5678;
    tick(); check("pre_rst_e1", o_data, 32'h4);
    tick(); check("pre_rst_e2", o_data, 32'h1234_5678);
    i_nrst = 1'b0;
    tick(); check("mid_rst", o_data, 32'h0000_0000);
    i_nrst = 1'b1;
    i_data = 32'h0000_0000;
    tick(); check("post_rst_zero_e1", o_data, 32'h0);
    tick(); check("post_rst_zero_e2", o_data, 32'h0);
    i_data = 32'h8000_0000;
    tick(); check("msb_e1", o_data, 32'h0);
    tick(); check("msb_e2", o_data, 32'h8000_0000);

    // Reset takes priority over a trigger pending in the same cycle.
    i_data = 32'h0000_0055;
    tick(); check("prio_arm", o_data, 32'h8000_0000);
    i_nrst = 1'b0;
    tick(); check("prio_rst", o_data, 32'h0);
    i_nrst = 1'b1;
    tick(); check("prio_after_e1", o_data, 32'h0);
    tick(); check("prio_after_e2", o_data, 32'h0000_0055);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_x_mux_trigger
`default_nettype wire
